// File: rtl/ps2_key_state_pkg.sv
// Set-2 scan codes, prefix FSM states and key indices shared by the PS/2 keyboard path.
// The map_code helper turns a (code, extended) pair into a held-bit index.
package ps2_key_state_pkg;

  localparam logic [7:0] CODE_W   = 8'h1D;
  localparam logic [7:0] CODE_A   = 8'h1C;
  localparam logic [7:0] CODE_S   = 8'h1B;
  localparam logic [7:0] CODE_D   = 8'h23;
  localparam logic [7:0] CODE_Z   = 8'h1A;
  localparam logic [7:0] CODE_X   = 8'h22;
  localparam logic [7:0] CODE_ENT = 8'h5A;
  localparam logic [7:0] CODE_UP  = 8'h75;
  localparam logic [7:0] CODE_DN  = 8'h72;
  localparam logic [7:0] CODE_LF  = 8'h6B;
  localparam logic [7:0] CODE_RT  = 8'h74;
  localparam logic [7:0] CODE_E0  = 8'hE0;
  localparam logic [7:0] CODE_F0  = 8'hF0;
  localparam logic [7:0] CODE_AA  = 8'hAA;
  localparam logic [7:0] CODE_FA  = 8'hFA;
  localparam logic [7:0] CODE_FE  = 8'hFE;
  localparam logic [7:0] CODE_00  = 8'h00;
  localparam logic [7:0] CODE_FF  = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } state_t;

  localparam int NUM_KEYS = 12;
  localparam int K_W     = 0;
  localparam int K_A     = 1;
  localparam int K_S     = 2;
  localparam int K_D     = 3;
  localparam int K_UP    = 4;
  localparam int K_DN    = 5;
  localparam int K_LF    = 6;
  localparam int K_RT    = 7;
  localparam int K_Z     = 8;
  localparam int K_X     = 9;
  localparam int K_ENT   = 10;
  localparam int K_KPENT = 11;

  typedef struct packed {
    logic       hit;
    logic [3:0] idx;
  } key_hit_t;

  // Non-extended 75/72/6B/74 are keypad keys and deliberately fall through to "no hit".
  function automatic key_hit_t map_code(input logic [7:0] code, input logic ext);
    key_hit_t r;
    r.hit = 1'b1;
    r.idx = 4'd0;
    if (!ext) begin
      case (code)
        CODE_W:   r.idx = 4'(K_W);
        CODE_A:   r.idx = 4'(K_A);
        CODE_S:   r.idx = 4'(K_S);
        CODE_D:   r.idx = 4'(K_D);
        CODE_Z:   r.idx = 4'(K_Z);
        CODE_X:   r.idx = 4'(K_X);
        CODE_ENT: r.idx = 4'(K_ENT);
        default:  r.hit = 1'b0;
      endcase
    end else begin
      case (code)
        CODE_UP:  r.idx = 4'(K_UP);
        CODE_DN:  r.idx = 4'(K_DN);
        CODE_LF:  r.idx = 4'(K_LF);
        CODE_RT:  r.idx = 4'(K_RT);
        CODE_ENT: r.idx = 4'(K_KPENT);
        default:  r.hit = 1'b0;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/ps2_key_state_if.sv
// Byte stream in from the PS/2 receiver and decoded key levels/pulses out to the game logic.
interface ps2_key_state_if;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       w;
  logic       a;
  logic       s;
  logic       d;
  logic       z;
  logic       x;
  logic       enter;
  logic [7:0] last_key;

  modport master (
    output byte_data, byte_valid,
    input  w, a, s, d, z, x, enter, last_key
  );

  modport slave (
    input  byte_data, byte_valid,
    output w, a, s, d, z, x, enter, last_key
  );
endinterface

// File: rtl/ps2_key_state.sv
// Decodes set-2 make/break/extended sequences into held-key levels, press pulses and last make code.
// Stale E0/F0 prefixes are dropped after TIMEOUT_CYCLES without a following byte.
module ps2_key_state
  import ps2_key_state_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
  parameter int unsigned CNT_W          = 21
) (
  input  logic           clk,
  input  logic           rst,
  ps2_key_state_if.slave kb
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_KEYS-1:0]   held_q, held_d;
  logic [7:0]            last_key_q, last_key_d;
  logic                  w_q, w_d, a_q, a_d, s_q, s_d, d_q, d_d, z_q, z_d;
  logic                  x_q, x_d, enter_q, enter_d;
  key_hit_t              std_hit, ext_hit;
  logic [7:0]            b;

  assign b       = kb.byte_data;
  assign std_hit = map_code(b, 1'b0);
  assign ext_hit = map_code(b, 1'b1);

  // Prefix FSM, held-bit update and timeout counter.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    held_d     = held_q;
    last_key_d = last_key_q;
    if (kb.byte_valid) begin
      cnt_d = '0;
      if (b == CODE_AA || b == CODE_00 || b == CODE_FF) begin
        held_d  = '0;
        state_d = ST_IDLE;
      end else if (b != CODE_FA && b != CODE_FE) begin
        case (state_q)
          ST_IDLE: begin
            if (b == CODE_E0) begin
              state_d = ST_EXT;
            end else if (b == CODE_F0) begin
              state_d = ST_BRK;
            end else if (std_hit.hit) begin
              held_d[std_hit.idx] = 1'b1;
              last_key_d          = b;
            end
          end
          ST_EXT: begin
            if (b == CODE_F0) begin
              state_d = ST_EXT_BRK;
            end else if (b != CODE_E0) begin
              state_d = ST_IDLE;
              if (ext_hit.hit) begin
                held_d[ext_hit.idx] = 1'b1;
                last_key_d          = b;
              end
            end
          end
          ST_BRK: begin
            if (b != CODE_F0) begin
              state_d = ST_IDLE;
              if (std_hit.hit) held_d[std_hit.idx] = 1'b0;
            end
          end
          ST_EXT_BRK: begin
            if (b != CODE_E0) begin
              state_d = ST_IDLE;
              if (ext_hit.hit) held_d[ext_hit.idx] = 1'b0;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end else if (state_q != ST_IDLE) begin
      // Saturate at the terminal count; the FSM leaves its prefix state on the same edge.
      if (cnt_q == TO_LAST) begin
        state_d = ST_IDLE;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Output stage: levels follow the new held bits, pulses compare new against previous.
  always_comb begin
    w_d     = held_d[K_W] | held_d[K_UP];
    a_d     = held_d[K_A] | held_d[K_LF];
    s_d     = held_d[K_S] | held_d[K_DN];
    d_d     = held_d[K_D] | held_d[K_RT];
    z_d     = held_d[K_Z];
    x_d     = held_d[K_X] & ~held_q[K_X];
    enter_d = (held_d[K_ENT] | held_d[K_KPENT]) & ~(held_q[K_ENT] | held_q[K_KPENT]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      held_q     <= '0;
      last_key_q <= 8'h00;
      w_q        <= 1'b0;
      a_q        <= 1'b0;
      s_q        <= 1'b0;
      d_q        <= 1'b0;
      z_q        <= 1'b0;
      x_q        <= 1'b0;
      enter_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      held_q     <= held_d;
      last_key_q <= last_key_d;
      w_q        <= w_d;
      a_q        <= a_d;
      s_q        <= s_d;
      d_q        <= d_d;
      z_q        <= z_d;
      x_q        <= x_d;
      enter_q    <= enter_d;
    end
  end

  assign kb.w        = w_q;
  assign kb.a        = a_q;
  assign kb.s        = s_q;
  assign kb.d        = d_q;
  assign kb.z        = z_q;
  assign kb.x        = x_q;
  assign kb.enter    = enter_q;
  assign kb.last_key = last_key_q;

endmodule
